pc_ctrl: RTL and testbench
==========================

# pc_ctrl

Parametrised program-counter unit for the processor fetch stage. It holds the PC register and selects the next PC from several sources: sequential, branch, jump, call, return and trap. Stalls are handled, misaligned targets are trapped, and an optional return-address stack (RAS) supplies return targets. It sits between the decode/execute control logic, which drives the select and target, and instruction memory, which is addressed by `PC`.

## Interface
- `SIZE`, 32: PC width in bits, ≥ 8.
- `RESET_VEC`, 32'h0000_0000: PC value loaded on reset. Width SIZE.
- `TRAP_VEC`, 32'h0000_0100: PC value loaded on a trap or misaligned target. Width SIZE.
- `RAS_DEPTH`, 4: number of RAS entries, power of two, ≥ 2.

Ports:
- `CLK`  in  1  clock; all state updates on the rising edge.
- `RESET_N`  in  1  asynchronous, active-low reset; clock `CLK`.
- `STALL`  in  1  high = hold PC and RAS.
- `PC_SEL`  in  3  next-PC source, type `pc_sel_t`: SEQ, BRANCH, JUMP, CALL, RET, TRAP.
- `TARGET`  in  SIZE  target for BRANCH/JUMP/CALL; fallback target for RET.
- `PC`  out  SIZE  current PC (registered).
- `PC_PLUS4`  out  SIZE  `PC + 4`, combinational, modulo 2^SIZE.
- `MISALIGN`  out  1  registered one-cycle pulse: a misaligned target was trapped.
- `RAS_EMPTY`  out  1  RAS holds no entries.
- `RAS_FULL`  out  1  RAS holds RAS_DEPTH entries.

## Operation
- Reset values: `PC` = RESET_VEC, `MISALIGN` = 0, RAS count = 0 (`RAS_EMPTY`=1, `RAS_FULL`=0). The RAS write pointer is reset to 0.
- Update priority at each rising edge, first match wins:
  1. `PC_SEL`=TRAP → PC ← TRAP_VEC. TRAP overrides `STALL`. RAS unchanged.
  2. `STALL`=1 → PC, RAS and MISALIGN are held. MISALIGN still clears after its one cycle.
  3. BRANCH/JUMP/CALL with `TARGET[1:0]` ≠ 0 → PC ← TRAP_VEC and MISALIGN ← 1. There is no RAS push.
  4. SEQ → PC ← PC_PLUS4. Wraps from 2^SIZE−4 to 0.
  5. BRANCH or JUMP → PC ← TARGET.
  6. CALL → PC ← TARGET and PC_PLUS4 is pushed onto the RAS.
  7. RET with RAS non-empty → PC ← top entry, then pop. RET with RAS empty → PC ← TARGET, with the same alignment check as rule 3.
- RAS overflow: a push when full overwrites the oldest entry (circular buffer). The count saturates at RAS_DEPTH and `RAS_FULL` stays 1.
- Undefined `PC_SEL` encodings behave as SEQ.
- A reset asserted mid-operation clears everything immediately, independent of `CLK`.

## Timing
- Latency: a select/target applied in cycle N appears on `PC` after the edge ending cycle N (one cycle).
- `PC_PLUS4` follows `PC` in the same cycle, with zero latency.
- `MISALIGN` is high for exactly the one cycle following the trapping edge, unless another misaligned target occurs on the next edge.
- `RAS_EMPTY`/`RAS_FULL` are registered and reflect the count after the most recent edge.
- There are no multi-cycle handshakes. The upstream block must hold `PC_SEL`/`TARGET` stable for as long as `STALL` is high.

## Configuration
- `PC_RAS_EN` defined: the RAS is instantiated and CALL/RET behave as described above.
- `PC_RAS_EN` undefined: no RAS storage. CALL behaves as JUMP, and RET behaves as JUMP to `TARGET`, including the alignment check. `RAS_EMPTY` is tied to 1 and `RAS_FULL` is tied to 0.

## Structure
- Package `pc_pkg` contains:
  - typedef enum `pc_sel_t` (SEQ=0, BRANCH=1, JUMP=2, CALL=3, RET=4, TRAP=5);
  - localparam `PC_INC` = 4;
  - default vector constants.
- Sub-module `pc_ras` holds the circular stack. It has ports push, pop, push data, top data, empty and full, and holds when stalled. It is instantiated only under `PC_RAS_EN`.

## Test plan
- Reset, then 3 cycles of SEQ → `PC` = 0, 4, 8, 12. Assert `RESET_N` low mid-sequence → `PC`=0 immediately.
- JUMP with `TARGET`=32'h40, then `STALL`=1 for 2 cycles with SEQ → `PC`=32'h40 held, then 32'h44 once `STALL` is released.
- BRANCH with `TARGET`=32'h42 → `PC`=32'h100 and `MISALIGN`=1 for one cycle, then 0.
- With `PC_RAS_EN`: CALL 0x200 from PC 0x10, CALL 0x300, RET, RET → `PC` = 0x200, 0x300, 0x204, 0x14 and `RAS_EMPTY`=1 at the end. Five CALLs at depth 4 → `RAS_FULL`=1, and the first return address is lost.
- RET on an empty RAS with `TARGET`=0x80 → `PC`=0x80. TRAP while `STALL`=1 → `PC`=32'h100.
- SEQ from `PC`=32'hFFFF_FFFC → `PC`=0.

Source files
------------

// File: rtl/pc_pkg.sv
// ============================================================================
//  Module   : pc_pkg
//  Brief    : Shared types and constants for the fetch-stage PC unit.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package pc_pkg;

    typedef enum logic [2:0] {
        SEQ    = 3'd0,
        BRANCH = 3'd1,
        JUMP   = 3'd2,
        CALL   = 3'd3,
        RET    = 3'd4,
        TRAP   = 3'd5
    } pc_sel_t;

    localparam int          PC_INC           = 4;
    localparam logic [31:0] PC_RESET_VEC_DEF = 32'h0000_0000;
    localparam logic [31:0] PC_TRAP_VEC_DEF  = 32'h0000_0100;

    // Instruction targets must be word aligned.
    function automatic logic is_misaligned(input logic [1:0] lsbs);
        return |lsbs;
    endfunction

endpackage

`default_nettype wire

// File: rtl/pc_ras.sv
// ============================================================================
//  Module   : pc_ras
//  Brief    : Circular return-address stack; a push when full overwrites the
//             oldest entry. Holds while stalled.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_ras #(
    parameter int SIZE      = 32,
    parameter int RAS_DEPTH = 4
) (
    input  logic            CLK,
    input  logic            RESET_N,
    input  logic            i_stall,
    input  logic            i_push,
    input  logic            i_pop,
    input  logic [SIZE-1:0] i_push_data,
    output logic [SIZE-1:0] o_top_data,
    output logic            o_empty,
    output logic            o_full
);

    localparam int c_PTR_W = $clog2(RAS_DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;

    logic [SIZE-1:0]    r_mem [RAS_DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_CNT_W-1:0] r_count;

    logic               w_do_push;
    logic               w_do_pop;
    logic [c_PTR_W-1:0] w_top_ptr;

    assign w_do_push = i_push & ~i_stall;
    assign w_do_pop  = i_pop & ~i_stall & ~o_empty;
    assign w_top_ptr = r_wr_ptr - c_PTR_W'(1);

    always_ff @(posedge CLK) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    // Once full, the write pointer sits on the oldest slot, so a further
    // push naturally overwrites it while the count saturates.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (w_do_push) begin
            r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            if (!o_full) begin
                r_count <= r_count + c_CNT_W'(1);
            end
        end else if (w_do_pop) begin
            r_wr_ptr <= w_top_ptr;
            r_count  <= r_count - c_CNT_W'(1);
        end
    end

    assign o_top_data = r_mem[w_top_ptr];
    assign o_empty    = (r_count == '0);
    assign o_full     = (r_count == c_CNT_W'(RAS_DEPTH));

endmodule

`default_nettype wire

// File: rtl/pc_ctrl.sv
// ============================================================================
//  Module   : pc_ctrl
//  Brief    : Fetch-stage program counter with stall, misalignment trap and
//             optional return-address stack (enabled by macro PC_RAS_EN).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_ctrl
    import pc_pkg::*;
#(
    parameter int              SIZE      = 32,
    parameter logic [SIZE-1:0] RESET_VEC = SIZE'(PC_RESET_VEC_DEF),
    parameter logic [SIZE-1:0] TRAP_VEC  = SIZE'(PC_TRAP_VEC_DEF),
    parameter int              RAS_DEPTH = 4
) (
    input  logic            CLK,
    input  logic            RESET_N,
    input  logic            STALL,
    input  logic [2:0]      PC_SEL,
    input  logic [SIZE-1:0] TARGET,
    output logic [SIZE-1:0] PC,
    output logic [SIZE-1:0] PC_PLUS4,
    output logic            MISALIGN,
    output logic            RAS_EMPTY,
    output logic            RAS_FULL
);

    logic [SIZE-1:0] r_pc;
    logic            r_misalign;
    logic [SIZE-1:0] w_pc_nxt;
    logic            w_mis_nxt;
    logic [SIZE-1:0] w_pc_plus4;
    logic            w_tgt_bad;

    assign w_pc_plus4 = r_pc + SIZE'(PC_INC);
    assign w_tgt_bad  = is_misaligned(TARGET[1:0]);

`ifdef PC_RAS_EN
    logic            w_push;
    logic            w_pop;
    logic [SIZE-1:0] w_ras_top;
    logic            w_ras_empty;
    logic            w_ras_full;

    pc_ras #(
        .SIZE      (SIZE),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .CLK         (CLK),
        .RESET_N     (RESET_N),
        .i_stall     (STALL),
        .i_push      (w_push),
        .i_pop       (w_pop),
        .i_push_data (w_pc_plus4),
        .o_top_data  (w_ras_top),
        .o_empty     (w_ras_empty),
        .o_full      (w_ras_full)
    );

    assign RAS_EMPTY = w_ras_empty;
    assign RAS_FULL  = w_ras_full;
`else
    assign RAS_EMPTY = 1'b1;
    // Constant 0 for every legal depth.
    assign RAS_FULL  = (RAS_DEPTH == 0);
`endif

    always_comb begin
        w_pc_nxt  = r_pc;
        w_mis_nxt = 1'b0;
`ifdef PC_RAS_EN
        w_push    = 1'b0;
        w_pop     = 1'b0;
`endif
        if (PC_SEL == TRAP) begin
            w_pc_nxt = TRAP_VEC;
        end else if (!STALL) begin
            case (PC_SEL)
                BRANCH, JUMP: begin
                    if (w_tgt_bad) begin
                        w_pc_nxt  = TRAP_VEC;
                        w_mis_nxt = 1'b1;
                    end else begin
                        w_pc_nxt  = TARGET;
                    end
                end
                CALL: begin
                    if (w_tgt_bad) begin
                        w_pc_nxt  = TRAP_VEC;
                        w_mis_nxt = 1'b1;
                    end else begin
                        w_pc_nxt  = TARGET;
`ifdef PC_RAS_EN
                        w_push    = 1'b1;
`endif
                    end
                end
                RET: begin
                    // Without a valid stack entry, TARGET is the fallback.
`ifdef PC_RAS_EN
                    if (!w_ras_empty) begin
                        w_pc_nxt  = w_ras_top;
                        w_pop     = 1'b1;
                    end else
`endif
                    if (w_tgt_bad) begin
                        w_pc_nxt  = TRAP_VEC;
                        w_mis_nxt = 1'b1;
                    end else begin
                        w_pc_nxt  = TARGET;
                    end
                end
                default: w_pc_nxt = w_pc_plus4;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_pc       <= RESET_VEC;
            r_misalign <= 1'b0;
        end else begin
            r_pc       <= w_pc_nxt;
            r_misalign <= w_mis_nxt;
        end
    end

    assign PC       = r_pc;
    assign PC_PLUS4 = w_pc_plus4;
    assign MISALIGN = r_misalign;

endmodule

`default_nettype wire

// File: tb/tb_pc_ctrl.sv
// ============================================================================
//  Module   : tb_pc_ctrl
//  Brief    : Directed, table-driven self-checking bench for pc_ctrl.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pc_ctrl;
    import pc_pkg::*;

    logic        CLK;
    logic        RESET_N;
    logic        STALL;
    logic [2:0]  PC_SEL;
    logic [31:0] TARGET;
    logic [31:0] PC;
    logic [31:0] PC_PLUS4;
    logic        MISALIGN;
    logic        RAS_EMPTY;
    logic        RAS_FULL;

    pc_ctrl u_dut (
        .CLK       (CLK),
        .RESET_N   (RESET_N),
        .STALL     (STALL),
        .PC_SEL    (PC_SEL),
        .TARGET    (TARGET),
        .PC        (PC),
        .PC_PLUS4  (PC_PLUS4),
        .MISALIGN  (MISALIGN),
        .RAS_EMPTY (RAS_EMPTY),
        .RAS_FULL  (RAS_FULL)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic        stall;
        logic [2:0]  sel;
        logic [31:0] tgt;
        logic [31:0] pc;
        logic        mis;
        logic        emp;
        logic        full;
    } vec_t;

    vec_t vq[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic void add(input logic st, input logic [2:0] sel, input logic [31:0] tgt,
                                input logic [31:0] pc, input logic mis, input logic emp,
                                input logic full);
        vec_t v;
        v.stall = st; v.sel = sel; v.tgt = tgt;
        v.pc = pc; v.mis = mis; v.emp = emp; v.full = full;
        vq.push_back(v);
    endfunction

    task automatic check_state(input string tag, input logic [31:0] pc, input logic mis,
                               input logic emp, input logic full);
        chk({tag, " PC"},        PC,        pc);
        chk({tag, " PC_PLUS4"},  PC_PLUS4,  pc + 32'd4);
        chk({tag, " MISALIGN"},  {31'd0, MISALIGN},  {31'd0, mis});
        chk({tag, " RAS_EMPTY"}, {31'd0, RAS_EMPTY}, {31'd0, emp});
        chk({tag, " RAS_FULL"},  {31'd0, RAS_FULL},  {31'd0, full});
    endtask

    initial begin
        RESET_N = 1'b0;
        STALL   = 1'b0;
        PC_SEL  = SEQ;
        TARGET  = 32'h0;
        repeat (2) @(posedge CLK);
        #1;
        check_state("reset", 32'h0, 1'b0, 1'b1, 1'b0);
        RESET_N = 1'b1;

        for (int i = 1; i <= 3; i++) begin
            @(posedge CLK);
            #1;
            check_state($sformatf("seq%0d", i), 32'(i * 4), 1'b0, 1'b1, 1'b0);
        end

        // Asynchronous reset between edges.
        #3;
        RESET_N = 1'b0;
        #1;
        chk("async reset PC", PC, 32'h0);
        @(posedge CLK);
        #1;
        RESET_N = 1'b1;
        check_state("post reset", 32'h0, 1'b0, 1'b1, 1'b0);

        add(0, JUMP,   32'h40, 32'h40,  0, 1, 0);
        add(1, SEQ,    32'h40, 32'h40,  0, 1, 0);
        add(1, SEQ,    32'h40, 32'h40,  0, 1, 0);
        add(0, SEQ,    32'h0,  32'h44,  0, 1, 0);
        add(0, BRANCH, 32'h42, 32'h100, 1, 1, 0);
        add(0, SEQ,    32'h0,  32'h104, 0, 1, 0);
        add(0, BRANCH, 32'h41, 32'h100, 1, 1, 0);
        add(0, JUMP,   32'h43, 32'h100, 1, 1, 0);
        add(1, SEQ,    32'h0,  32'h100, 0, 1, 0);
        add(0, JUMP,   32'h20, 32'h20,  0, 1, 0);
        add(1, TRAP,   32'h0,  32'h100, 0, 1, 0);
        add(0, JUMP,   32'h10, 32'h10,  0, 1, 0);
`ifdef PC_RAS_EN
        add(0, CALL,   32'h200,  32'h200,  0, 0, 0);
        add(0, CALL,   32'h300,  32'h300,  0, 0, 0);
        add(0, RET,    32'h0,    32'h204,  0, 0, 0);
        add(0, RET,    32'h0,    32'h14,   0, 1, 0);
        add(0, RET,    32'h80,   32'h80,   0, 1, 0);
        add(0, RET,    32'h82,   32'h100,  1, 1, 0);
        add(0, CALL,   32'h302,  32'h100,  1, 1, 0);
        add(0, CALL,   32'h1000, 32'h1000, 0, 0, 0);
        add(0, CALL,   32'h2000, 32'h2000, 0, 0, 0);
        add(0, CALL,   32'h3000, 32'h3000, 0, 0, 0);
        add(0, CALL,   32'h4000, 32'h4000, 0, 0, 1);
        add(0, CALL,   32'h5000, 32'h5000, 0, 0, 1);
        add(1, RET,    32'h0,    32'h5000, 0, 0, 1);
        add(0, RET,    32'h0,    32'h4004, 0, 0, 0);
        add(0, RET,    32'h0,    32'h3004, 0, 0, 0);
        add(0, RET,    32'h0,    32'h2004, 0, 0, 0);
        add(0, RET,    32'h0,    32'h1004, 0, 1, 0);
        add(0, RET,    32'h88,   32'h88,   0, 1, 0);
`else
        add(0, CALL,   32'h200,  32'h200,  0, 1, 0);
        add(0, CALL,   32'h300,  32'h300,  0, 1, 0);
        add(0, RET,    32'h80,   32'h80,   0, 1, 0);
        add(0, RET,    32'h82,   32'h100,  1, 1, 0);
        add(0, CALL,   32'h302,  32'h100,  1, 1, 0);
        add(0, RET,    32'h88,   32'h88,   0, 1, 0);
`endif
        add(0, 3'd6,   32'h0,        32'h8C,       0, 1, 0);
        add(0, 3'd7,   32'h0,        32'h90,       0, 1, 0);
        add(0, JUMP,   32'hFFFF_FFFC, 32'hFFFF_FFFC, 0, 1, 0);
        add(0, SEQ,    32'h0,        32'h0,        0, 1, 0);

        foreach (vq[i]) begin
            STALL  = vq[i].stall;
            PC_SEL = vq[i].sel;
            TARGET = vq[i].tgt;
            @(posedge CLK);
            #1;
            check_state($sformatf("v%0d", i), vq[i].pc, vq[i].mis, vq[i].emp, vq[i].full);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
